// File: rtl/code_player.sv
// code_player: plays a latched sequence of 2-bit direction symbols as timed,
// registered one-hot pulses on U/L/R/D. These pulses stand in for the
// debounced button strobes of the direction lock.
// Optional seven-segment readout of the symbol being sent: define CODE_PLAYER_SSG_EN.
module code_player #(
  parameter int unsigned CODE_LEN  = 4,
  parameter int unsigned PULSE_CYC = 4,
  parameter int unsigned GAP_CYC   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [2*CODE_LEN-1:0] code,
  output logic                  U,
  output logic                  L,
  output logic                  R,
  output logic                  D,
  output logic                  busy,
  output logic                  done,
  output logic [6:0]            SSG_D,
  output logic [2:0]            SSG_EN
);

  localparam int unsigned MaxCyc = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
  localparam int unsigned TimerW = (MaxCyc > 1) ? $clog2(MaxCyc) : 1;
  localparam logic [2:0]  LastIdx = 3'(CODE_LEN - 1);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StPulse  = 2'd1;
  localparam logic [1:0] StGap    = 2'd2;
  localparam logic [1:0] StFinish = 2'd3;

  logic [1:0]            r_state, w_state_d;
  logic [2*CODE_LEN-1:0] r_code, w_code_d;
  logic [2:0]            r_idx, w_idx_d;
  logic [TimerW-1:0]     r_timer, w_timer_d;
  logic [3:0]            r_dir, w_dir_d;
  logic                  r_busy, r_done;
  logic [2*CODE_LEN-1:0] w_shifted;
  logic [1:0]            w_sym;

  // Next-state logic: the timer counts down from phase length minus one.
  always_comb begin
    w_state_d = r_state;
    w_code_d  = r_code;
    w_idx_d   = r_idx;
    w_timer_d = r_timer;
    unique case (r_state)
      StIdle: begin
        if (start && !abort) begin
          w_code_d  = code;
          w_idx_d   = '0;
          w_timer_d = TimerW'(PULSE_CYC - 1);
          w_state_d = StPulse;
        end
      end
      StPulse: begin
        if (abort) begin
          w_state_d = StIdle;
          w_timer_d = '0;
        end else if (r_timer == '0) begin
          w_state_d = StGap;
          w_timer_d = TimerW'(GAP_CYC - 1);
        end else begin
          w_timer_d = r_timer - TimerW'(1);
        end
      end
      StGap: begin
        if (abort) begin
          w_state_d = StIdle;
          w_timer_d = '0;
        end else if (r_timer == '0) begin
          if (r_idx == LastIdx) begin
            w_state_d = StFinish;
          end else begin
            w_idx_d   = r_idx + 3'd1;
            w_timer_d = TimerW'(PULSE_CYC - 1);
            w_state_d = StPulse;
          end
        end else begin
          w_timer_d = r_timer - TimerW'(1);
        end
      end
      default: begin
        // FINISH always returns to IDLE; abort here has the same effect.
        w_state_d = StIdle;
        w_timer_d = '0;
      end
    endcase
  end

  // Symbol about to be shown, taken from next-state so outputs line up with state.
  assign w_shifted = w_code_d >> {w_idx_d, 1'b0};
  assign w_sym     = w_shifted[1:0];

  // One-hot direction decode: bit 0=U, 1=L, 2=R, 3=D.
  always_comb begin
    w_dir_d = '0;
    if (w_state_d == StPulse) begin
      w_dir_d[w_sym] = 1'b1;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= StIdle;
      r_code  <= '0;
      r_idx   <= '0;
      r_timer <= '0;
      r_dir   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_code  <= w_code_d;
      r_idx   <= w_idx_d;
      r_timer <= w_timer_d;
      r_dir   <= w_dir_d;
      r_busy  <= (w_state_d != StIdle);
      r_done  <= (w_state_d == StFinish);
    end
  end

  assign U      = r_dir[0];
  assign L      = r_dir[1];
  assign R      = r_dir[2];
  assign D      = r_dir[3];
  assign busy   = r_busy;
  assign done   = r_done;
  assign SSG_EN = 3'b111;

`ifdef CODE_PLAYER_SSG_EN
  localparam logic [6:0] SegU     = 7'b1000001;
  localparam logic [6:0] SegL     = 7'b1000111;
  localparam logic [6:0] SegR     = 7'b0101111;
  localparam logic [6:0] SegD     = 7'b0100001;
  localparam logic [6:0] SegBlank = 7'b1111111;

  logic [6:0] r_ssg, w_ssg_d;

  // Segment pattern for the symbol in flight; blank outside PULSE/GAP.
  always_comb begin
    w_ssg_d = SegBlank;
    if (w_state_d == StPulse || w_state_d == StGap) begin
      unique case (w_sym)
        2'b00:   w_ssg_d = SegU;
        2'b01:   w_ssg_d = SegL;
        2'b10:   w_ssg_d = SegR;
        default: w_ssg_d = SegD;
      endcase
    end
  end

  // Display register, updated on the same edge as the direction outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ssg <= SegBlank;
    end else begin
      r_ssg <= w_ssg_d;
    end
  end

  assign SSG_D = r_ssg;
`else
  assign SSG_D = 7'b1111111;
`endif

endmodule

// File: tb/tb_code_player.sv
// Scoreboard bench for code_player: expected per-cycle output vectors are derived
// from the pulse/gap timing formulas and queued when a start is driven.
module tb_code_player;

  localparam int unsigned CodeLen  = 4;
  localparam int unsigned PulseCyc = 4;
  localparam int unsigned GapCyc   = 4;
  localparam int          Period   = PulseCyc + GapCyc;
  localparam int          Total    = CodeLen * Period + 1;  // cycle carrying done
  localparam logic [12:0] IdleVec  = 13'h007F;

  logic                 clk = 1'b0;
  logic                 reset, start, abort;
  logic [2*CodeLen-1:0] code;
  logic                 U, L, R, D, busy, done;
  logic [6:0]           SSG_D;
  logic [2:0]           SSG_EN;
  logic [12:0]          obs;

  logic [12:0] exp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  code_player #(
    .CODE_LEN (CodeLen),
    .PULSE_CYC(PulseCyc),
    .GAP_CYC  (GapCyc)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .abort (abort),
    .code  (code),
    .U     (U),
    .L     (L),
    .R     (R),
    .D     (D),
    .busy  (busy),
    .done  (done),
    .SSG_D (SSG_D),
    .SSG_EN(SSG_EN)
  );

  always #5 clk = ~clk;

  assign obs = {U, L, R, D, busy, done, SSG_D};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", tag, got, want, $time);
    end
  endtask

  // Expected {U,L,R,D,busy,done,SSG_D} in cycle c (1-based) after a start at cycle 0.
  function automatic logic [12:0] expect_at(input logic [2*CodeLen-1:0] c_code, input int c);
    logic [12:0] v;
    logic [1:0]  sym;
    int          k, ph;
    v = IdleVec;
    if (c >= 1 && c < Total) begin
      k   = (c - 1) / Period;
      ph  = (c - 1) % Period;
      sym = c_code[2*k +: 2];
      v[8] = 1'b1;
      if (ph < PulseCyc) begin
        case (sym)
          2'b00:   v[12] = 1'b1;
          2'b01:   v[11] = 1'b1;
          2'b10:   v[10] = 1'b1;
          default: v[9]  = 1'b1;
        endcase
      end
`ifdef CODE_PLAYER_SSG_EN
      case (sym)
        2'b00:   v[6:0] = 7'b1000001;
        2'b01:   v[6:0] = 7'b1000111;
        2'b10:   v[6:0] = 7'b0101111;
        default: v[6:0] = 7'b0100001;
      endcase
`endif
    end else if (c == Total) begin
      v[8] = 1'b1;
      v[7] = 1'b1;
    end
    return v;
  endfunction

  task automatic pop_check(input string tag);
    if (exp_q.size() == 0) begin
      check_eq({tag, "_qempty"}, 32'd0, 32'd1);
    end else begin
      check_eq(tag, {19'd0, obs}, {19'd0, exp_q.pop_front()});
    end
  endtask

  // Drive a start just before edge 0, queue the expected trace, and compare
  // cycle by cycle. abort_cyc/rst_cyc of 0 disable the respective event.
  task automatic run_seq(input logic [2*CodeLen-1:0] c_code, input int abort_cyc,
                         input int rst_cyc, input bit hold, input string tag);
    int          n_chk;
    int          cc;
    logic [12:0] e;
    code  = c_code;
    start = 1'b1;
    n_chk = hold ? 2 * (Total + 1) : Total + 1;
    for (int c = 1; c <= n_chk; c++) begin
      cc = hold ? ((c - 1) % (Total + 1)) + 1 : c;
      e  = expect_at(c_code, cc);
      if (abort_cyc > 0 && c > abort_cyc) e = IdleVec;
      exp_q.push_back(e);
    end
    for (int c = 1; c <= n_chk; c++) begin
      @(negedge clk);
      pop_check(tag);
      if (!hold || c == Total + 2) start = 1'b0;
      if (c == 2 && !hold) code = ~c_code;  // must not affect the latched sequence
      abort = (c == abort_cyc);
      if (c == rst_cyc) begin
        #2 reset = 1'b0;
        #1 check_eq({tag, "_rst_async"}, {19'd0, obs}, {19'd0, IdleVec});
        exp_q.delete();
        @(negedge clk);
        check_eq({tag, "_rst_hold"}, {19'd0, obs}, {19'd0, IdleVec});
        reset = 1'b1;
        break;
      end
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    code  = '0;
    repeat (2) @(negedge clk);
    check_eq("reset_vec", {19'd0, obs}, {19'd0, IdleVec});
    check_eq("ssg_en", {29'd0, SSG_EN}, 32'd7);
    reset = 1'b1;
    @(negedge clk);
    check_eq("idle_after_rst", {19'd0, obs}, {19'd0, IdleVec});

    // Full playback U, L, R, D.
    run_seq(8'b11_10_01_00, 0, 0, 1'b0, "seq_basic");
    // start held through playback: one idle cycle, then exactly one more sequence.
    run_seq(8'b00_01_10_11, 0, 0, 1'b1, "seq_hold");
    // abort mid-pulse of L.
    run_seq(8'b11_10_01_00, 10, 0, 1'b0, "seq_abort");

    // start and abort together in IDLE: dropped.
    start = 1'b1;
    abort = 1'b1;
    for (int i = 0; i < 4; i++) exp_q.push_back(IdleVec);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      pop_check("start_abort");
      start = 1'b0;
      abort = 1'b0;
    end

    // Reset mid-pulse of R, then a fresh run from symbol 0.
    run_seq(8'b11_10_01_00, 0, 18, 1'b0, "seq_reset");
    run_seq(8'b11_10_01_00, 0, 0, 1'b0, "seq_after_rst");
    // Display pattern run (blank throughout without the display option).
    run_seq(8'b00_00_00_11, 0, 0, 1'b0, "seq_ssg");
    // Random codes.
    for (int i = 0; i < 3; i++) begin
      run_seq(8'($urandom), 0, 0, 1'b0, "seq_rand");
    end

    check_eq("q_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
